fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer. Fetches one instruction at a time from a
//   synchronous instruction memory (1-cycle read latency), presents it to the
//   decoder with a valid/ready handshake, and steps the PC sequentially, to a
//   branch target, or stops on HALT. Counts retired (accepted) instructions.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   start, start_addr    one-cycle launch pulse and first PC (IDLE/HALTED only)
//   imem_en, imem_addr   memory read request (imem_addr always equals pc)
//   imem_rdata           memory read data, valid the cycle after imem_en
//   instr_out, pc_out    registered instruction and its address
//   instr_valid          instr_out/pc_out valid
//   instr_ready          decoder accepts this cycle
//   branch, branch_taken, branch_target, halt
//                        decoder feedback, only sampled on accept
//   done                 program has halted
//   instr_count          saturating count of accepted instructions
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 9,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_addr,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic                   branch,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   halt,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, HALTED} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;

    assign imem_addr = pc;

    // imem_en and done are registered: they are set on the transition into
    // FETCH / HALTED so they are high for exactly the cycles spent there.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            imem_en     <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc          <= start_addr;
                        instr_count <= '0;
                        done        <= 1'b0;
                        imem_en     <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Read issued this cycle; data lands during LATCH.
                    imem_en <= 1'b0;
                    state   <= LATCH;
                end
                LATCH: begin
                    instr_out   <= imem_rdata;
                    pc_out      <= pc;
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (instr_count != {CNT_WIDTH{1'b1}})
                            instr_count <= instr_count + 1'b1;
                        // HALT wins over a simultaneously flagged branch.
                        if (halt) begin
                            done  <= 1'b1;
                            state <= HALTED;
                        end else begin
                            if (branch && branch_taken)
                                pc <= branch_target;
                            else
                                pc <= pc + 1'b1;
                            imem_en <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int PW = 8;
    localparam int IW = 9;
    localparam int CW = 4;   // narrow counter so saturation is reachable quickly

    localparam logic [IW-1:0] ADD    = 9'h001;
    localparam logic [IW-1:0] BR     = 9'h080;
    localparam logic [IW-1:0] HALT   = 9'h100;
    localparam logic [IW-1:0] BRHALT = 9'h180;

    logic          clk, reset, start, imem_en, instr_valid, instr_ready;
    logic          branch, branch_taken, halt, done;
    logic [PW-1:0] start_addr, imem_addr, pc_out, branch_target;
    logic [IW-1:0] imem_rdata, instr_out;
    logic [CW-1:0] instr_count;

    logic [IW-1:0] rom [256];
    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .branch(branch), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .done(done),
        .instr_count(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data valid the cycle after imem_en.
    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    // Toy decoder: bit 8 = HALT, bit 7 = branch.
    assign halt   = instr_out[8];
    assign branch = instr_out[7];

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) return;
        end
        checks++; errors++;
        $display("FAIL %s: instr_valid timeout, got 0 expected 1", name);
    endtask

    task automatic do_start(input logic [PW-1:0] a);
        start = 1'b1; start_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(negedge clk);
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %0h exp 0", imem_en); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", instr_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0h exp 0", done); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0h exp 0", instr_count); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %0h exp 0", imem_addr); end
        checks++; if (pc_out !== 8'h00 || instr_out !== 9'h000) begin errors++; $display("FAIL rst_out: got pc %0h instr %0h exp 0 0", pc_out, instr_out); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL idle_en: got %0h exp 0", imem_en); end
    endtask

    task automatic test_program;
        rom[8'h10] = ADD; rom[8'h11] = ADD; rom[8'h12] = HALT;
        instr_ready = 1'b1;
        do_start(8'h10);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h10) begin errors++; $display("FAIL prog_fetch: got en %0h addr %0h exp 1 10", imem_en, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            wait_valid("prog_valid");
            checks++; if (pc_out !== 8'h10 + i[7:0]) begin errors++; $display("FAIL prog_pc: got %0h exp %0h", pc_out, 8'h10 + i[7:0]); end
            checks++; if (instr_out !== rom[8'h10 + i[7:0]]) begin errors++; $display("FAIL prog_instr: got %0h exp %0h", instr_out, rom[8'h10 + i[7:0]]); end
            checks++; if (instr_count !== i[CW-1:0]) begin errors++; $display("FAIL prog_cnt: got %0d exp %0d", instr_count, i); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL prog_done: got %0h exp 1", done); end
        checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL prog_cnt3: got %0d exp 3", instr_count); end
        checks++; if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL prog_halted: got valid %0h en %0h exp 0 0", instr_valid, imem_en); end
    endtask

    task automatic test_stall;
        rom[8'h20] = ADD; rom[8'h21] = HALT;
        instr_ready = 1'b0;
        do_start(8'h20);
        wait_valid("stall_valid");
        for (int k = 0; k < 5; k++) begin
            checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h20 || instr_out !== ADD) begin errors++; $display("FAIL stall_hold: got v %0h pc %0h instr %0h exp 1 20 %0h", instr_valid, pc_out, instr_out, ADD); end
            checks++; if (imem_en !== 1'b0 || instr_count !== 4'd0) begin errors++; $display("FAIL stall_quiet: got en %0h cnt %0d exp 0 0", imem_en, instr_count); end
            // Start pulsed mid-ISSUE must be ignored.
            if (k == 2) begin start = 1'b1; start_addr = 8'h55; end
            if (k == 3) start = 1'b0;
            @(negedge clk);
        end
        checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h20) begin errors++; $display("FAIL stall_6th: got v %0h pc %0h exp 1 20", instr_valid, pc_out); end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h21) begin errors++; $display("FAIL stall_next: got en %0h addr %0h exp 1 21", imem_en, imem_addr); end
        checks++; if (instr_count !== 4'd1) begin errors++; $display("FAIL stall_cnt: got %0d exp 1", instr_count); end
        wait_valid("stall_valid2");
        @(negedge clk);
    endtask

    task automatic test_branch;
        rom[8'h30] = BR; rom[8'h40] = BR; rom[8'h41] = BRHALT;
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        do_start(8'h30);
        wait_valid("br_valid1");
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL br_taken: got en %0h addr %0h exp 1 40", imem_en, imem_addr); end
        branch_taken = 1'b0;
        wait_valid("br_valid2");
        checks++; if (pc_out !== 8'h40) begin errors++; $display("FAIL br_pc: got %0h exp 40", pc_out); end
        @(negedge clk);
        checks++; if (imem_addr !== 8'h41) begin errors++; $display("FAIL br_not_taken: got %0h exp 41", imem_addr); end
        branch_taken = 1'b1; branch_target = 8'h60;
        wait_valid("br_valid3");
        @(negedge clk);
        checks++; if (done !== 1'b1 || imem_en !== 1'b0) begin errors++; $display("FAIL br_halt: got done %0h en %0h exp 1 0", done, imem_en); end
        checks++; if (imem_addr !== 8'h41) begin errors++; $display("FAIL br_halt_pc: got %0h exp 41", imem_addr); end
    endtask

    task automatic test_wrap;
        rom[8'hFF] = ADD; rom[8'h00] = HALT;
        branch_taken = 1'b0;
        do_start(8'hFF);
        wait_valid("wrap_valid1");
        checks++; if (pc_out !== 8'hFF) begin errors++; $display("FAIL wrap_pc: got %0h exp ff", pc_out); end
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got en %0h addr %0h exp 1 0", imem_en, imem_addr); end
        wait_valid("wrap_valid2");
        checks++; if (pc_out !== 8'h00 || instr_out !== HALT) begin errors++; $display("FAIL wrap_pc0: got pc %0h instr %0h exp 0 %0h", pc_out, instr_out, HALT); end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        bit seen;
        for (int a = 8'h80; a < 8'h94; a++) rom[a] = ADD;
        rom[8'h94] = HALT;
        do_start(8'h80);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL sat_done: got 0 expected 1"); end
        checks++; if (instr_count !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d exp 15", instr_count); end
    endtask

    task automatic test_restart;
        rom[8'h05] = HALT;
        do_start(8'h05);
        checks++; if (done !== 1'b0 || instr_count !== 4'd0) begin errors++; $display("FAIL restart_clr: got done %0h cnt %0d exp 0 0", done, instr_count); end
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h05) begin errors++; $display("FAIL restart_fetch: got en %0h addr %0h exp 1 5", imem_en, imem_addr); end
        wait_valid("restart_valid");
        @(negedge clk);
    endtask

    task automatic test_reset_issue;
        for (int a = 8'hA0; a < 8'hA8; a++) rom[a] = ADD;
        instr_ready = 1'b1;
        do_start(8'hA0);
        for (int i = 0; i < 8; i++) wait_valid("rstiss_valid");
        checks++; if (instr_count !== 4'd7 || pc_out !== 8'hA7) begin errors++; $display("FAIL rstiss_pre: got cnt %0d pc %0h exp 7 a7", instr_count, pc_out); end
        // Reset, start and accept all in the same cycle: reset wins.
        reset = 1'b0; start = 1'b1; start_addr = 8'h33;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstiss_ctl: got v %0h en %0h done %0h exp 0 0 0", instr_valid, imem_en, done); end
        checks++; if (instr_count !== 4'd0 || pc_out !== 8'h00 || instr_out !== 9'h000 || imem_addr !== 8'h00) begin errors++; $display("FAIL rstiss_data: got cnt %0d pc %0h instr %0h addr %0h exp 0 0 0 0", instr_count, pc_out, instr_out, imem_addr); end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++; if (imem_en !== 1'b0 || imem_addr !== 8'h00) begin errors++; $display("FAIL rstiss_idle: got en %0h addr %0h exp 0 0", imem_en, imem_addr); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = ADD;
        test_reset;
        test_program;
        test_stall;
        test_branch;
        test_wrap;
        test_saturate;
        test_restart;
        test_reset_issue;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
